// File: rtl/mips_mem_arbiter.sv
// Arbitrates the MIPS fetch and load/store ports onto one single-port synchronous word RAM.
// Optional macro MEM_ARB_RR_EN: round-robin on ties (default build: fixed priority, D over I).
module mips_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                mem_en_q, mem_en_d;
  logic [BE_W-1:0]     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                pick_d;

`ifdef MEM_ARB_RR_EN
  owner_t last_grant_q, last_grant_d;
  // A tie goes to whichever port did not win most recently.
  assign pick_d = d_req && (!i_req || (last_grant_q == OWN_I));
`else
  // The load/store belongs to the older instruction, so it always wins a tie.
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          if (pick_d) begin
            owner_d    = OWN_D;
            mem_addr_d = d_addr;
            if (d_we) begin
              mem_we_d    = d_be;
              mem_wdata_d = d_wdata;
            end else begin
              mem_we_d = '0;
            end
          end else begin
            owner_d    = OWN_I;
            mem_addr_d = i_addr;
            mem_we_d   = '0;
          end
`ifdef MEM_ARB_RR_EN
          last_grant_d = owner_d;
`endif
        end
      end
      ACCESS: begin
        state_d  = RESPOND;
        mem_en_d = 1'b0;
        mem_we_d = '0;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= OWN_D;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign i_ack     = (state_q == RESPOND) && (owner_q == OWN_I);
  assign d_ack     = (state_q == RESPOND) && (owner_q == OWN_D);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural byte-writable synchronous RAM.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [256];

  mips_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_we[k]) ram[mem_addr][k*8 +: 8] <= mem_wdata[k*8 +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = '0;
    ram[3] = 32'h20020005;
    ram[5] = 32'h11223344;

    // Reset with random inputs.
    rst = 1'b1;
    i_req = 1'($urandom); i_addr = 8'($urandom);
    d_req = 1'($urandom); d_we = 1'($urandom); d_addr = 8'($urandom);
    d_wdata = $urandom; d_be = 4'($urandom);
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    rst = 1'b0; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    step();

    // Fetch read of word 3.
    i_req = 1'b1; i_addr = 8'h03;
    #0 check("fetch_t_mem_en", 32'(mem_en), 32'd0);
    step();
    check("fetch_t1_mem_en", 32'(mem_en), 32'd1);
    check("fetch_t1_addr", 32'(mem_addr), 32'h03);
    check("fetch_t1_we", 32'(mem_we), 32'd0);
    check("fetch_t1_busy", 32'(busy), 32'd1);
    check("fetch_t1_ack", 32'(i_ack), 32'd0);
    step();
    check("fetch_t2_ack", 32'(i_ack), 32'd1);
    check("fetch_t2_rdata", i_rdata, 32'h20020005);
    check("fetch_t2_dack", 32'(d_ack), 32'd0);
    check("fetch_t2_mem_en", 32'(mem_en), 32'd0);
    i_req = 1'b0;
    step();
    check("fetch_t3_ack", 32'(i_ack), 32'd0);
    check("fetch_t3_busy", 32'(busy), 32'd0);

    // Full store to word 1, then load it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h01; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    step();
    check("store_t1_we", 32'(mem_we), 32'hF);
    check("store_t1_wdata", mem_wdata, 32'hDEADBEEF);
    check("store_t1_addr", 32'(mem_addr), 32'h01);
    step();
    check("store_t2_we", 32'(mem_we), 32'h0);
    check("store_t2_dack", 32'(d_ack), 32'd1);
    check("store_t2_iack", 32'(i_ack), 32'd0);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
    step();
    check("load1_t1_we", 32'(mem_we), 32'h0);
    step();
    check("load1_t2_dack", 32'(d_ack), 32'd1);
    check("load1_t2_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    step();

    // Partial store of byte 1 into word 5, then readback.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 32'h0000AB00; d_be = 4'h2;
    step();
    check("pstore_t1_we", 32'(mem_we), 32'h2);
    step();
    check("pstore_t2_dack", 32'(d_ack), 32'd1);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0;
    step();
    step();
    check("pload_t2_rdata", d_rdata, 32'h1122AB44);
    d_req = 1'b0;
    step();

    // Tie: fetch word 3 and load word 5 together; D wins under fixed priority.
`ifndef MEM_ARB_RR_EN
    i_req = 1'b1; i_addr = 8'h03;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
    step();
    check("tie_t1_addr", 32'(mem_addr), 32'h05);
    step();
    check("tie_t2_dack", 32'(d_ack), 32'd1);
    check("tie_t2_iack", 32'(i_ack), 32'd0);
    check("tie_t2_drdata", d_rdata, 32'h1122AB44);
    d_req = 1'b0;
    step();
    check("tie_t3_iack", 32'(i_ack), 32'd0);
    step();
    check("tie_t4_addr", 32'(mem_addr), 32'h03);
    step();
    check("tie_t5_iack", 32'(i_ack), 32'd1);
    check("tie_t5_dack", 32'(d_ack), 32'd0);
    check("tie_t5_irdata", i_rdata, 32'h20020005);
    i_req = 1'b0;
    step();
`else
    // Both requests held continuously: grants alternate I, D, I, D.
    i_req = 1'b1; i_addr = 8'h03;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
    for (int g = 0; g < 4; g++) begin
      step();
      step();
      check("rr_iack", 32'(i_ack), (g % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_dack", 32'(d_ack), (g % 2 == 0) ? 32'd0 : 32'd1);
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
`endif

    // Reset during ACCESS of a fetch.
    i_req = 1'b1; i_addr = 8'h03;
    step();
    check("rstacc_t1_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; i_req = 1'b0;
    check("rstacc_t2_iack", 32'(i_ack), 32'd0);
    check("rstacc_t2_busy", 32'(busy), 32'd0);
    check("rstacc_t2_mem_en", 32'(mem_en), 32'd0);
    check("rstacc_t2_addr", 32'(mem_addr), 32'd0);
    step();
    check("rstacc_t3_iack", 32'(i_ack), 32'd0);
    check("rstacc_t3_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
